// File: rtl/fcore_alu_pkg.sv
// Shared opcode and flag definitions for the fcore pipelined ALU.
package fcore_alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SHL    = 4'd5,
    ALU_SHR    = 4'd6,
    ALU_CMP_GT = 4'd7
  } alu_op_t;

  localparam int unsigned FLAG_ZERO  = 0;
  localparam int unsigned FLAG_NEG   = 1;
  localparam int unsigned FLAG_CARRY = 2;
  localparam int unsigned FLAG_OVF   = 3;

  localparam logic [3:0] FLAGS_RESERVED = 4'b0001;

endpackage

// File: rtl/alu_operand_join.sv
// Per-operand holding slots; pairs operands in arrival order and qualifies the join.
module alu_operand_join #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  stall,
  output logic                  join_fire,
  output logic [DATA_WIDTH-1:0] hold_a_data,
  output logic [DATA_WIDTH-1:0] hold_b_data
);

  logic                  hold_a_valid_q, hold_a_valid_d;
  logic                  hold_b_valid_q, hold_b_valid_d;
  logic [DATA_WIDTH-1:0] hold_a_data_q, hold_a_data_d;
  logic [DATA_WIDTH-1:0] hold_b_data_q, hold_b_data_d;
  logic                  a_hs, b_hs;

  // A slot draining through the join may accept a new operand in the same cycle.
  always_comb begin
    join_fire      = hold_a_valid_q && hold_b_valid_q && !stall;
    a_ready        = !hold_a_valid_q || join_fire;
    b_ready        = !hold_b_valid_q || join_fire;
    a_hs           = a_valid && a_ready;
    b_hs           = b_valid && b_ready;
    hold_a_valid_d = a_hs || (hold_a_valid_q && !join_fire);
    hold_b_valid_d = b_hs || (hold_b_valid_q && !join_fire);
    hold_a_data_d  = a_hs ? a_data : hold_a_data_q;
    hold_b_data_d  = b_hs ? b_data : hold_b_data_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_a_valid_q <= 1'b0;
      hold_b_valid_q <= 1'b0;
      hold_a_data_q  <= '0;
      hold_b_data_q  <= '0;
    end else begin
      hold_a_valid_q <= hold_a_valid_d;
      hold_b_valid_q <= hold_b_valid_d;
      hold_a_data_q  <= hold_a_data_d;
      hold_b_data_q  <= hold_b_data_d;
    end
  end

  assign hold_a_data = hold_a_data_q;
  assign hold_b_data = hold_b_data_q;

endmodule

// File: rtl/pipelined_alu.sv
// Pipelined ALU: joins two operand streams, executes, and carries result and flags
// through STAGES valid-tagged registers with full backpressure.
module pipelined_alu
  import fcore_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STAGES     = 1,
  parameter bit          SATURATE   = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] operand_a_data,
  input  logic                  operand_a_valid,
  output logic                  operand_a_ready,
  input  logic [DATA_WIDTH-1:0] operand_b_data,
  input  logic                  operand_b_valid,
  output logic                  operand_b_ready,
  input  logic [3:0]            operation,
  output logic [DATA_WIDTH-1:0] result_data,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [3:0]            flags
);

  localparam int unsigned   W    = DATA_WIDTH;
  localparam int unsigned   SHW  = $clog2(DATA_WIDTH);
  localparam logic [W-1:0]  SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  SMIN = {1'b1, {(W-1){1'b0}}};

  logic          stall;
  logic          join_fire;
  logic [W-1:0]  op_a, op_b;

  alu_operand_join #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_join (
    .clock      (clock),
    .reset      (reset),
    .a_data     (operand_a_data),
    .a_valid    (operand_a_valid),
    .a_ready    (operand_a_ready),
    .b_data     (operand_b_data),
    .b_valid    (operand_b_valid),
    .b_ready    (operand_b_ready),
    .stall      (stall),
    .join_fire  (join_fire),
    .hold_a_data(op_a),
    .hold_b_data(op_b)
  );

  logic [W:0]    sum_w, diff_w;
  logic [W-1:0]  exec_res;
  logic [3:0]    exec_flags;
  logic          ovf, carry, reserved;

  always_comb begin
    sum_w    = {1'b0, op_a} + {1'b0, op_b};
    diff_w   = {1'b0, op_a} - {1'b0, op_b};
    exec_res = '0;
    ovf      = 1'b0;
    carry    = 1'b0;
    reserved = 1'b0;
    case (operation)
      ALU_ADD: begin
        exec_res = sum_w[W-1:0];
        carry    = sum_w[W];
        ovf      = (op_a[W-1] == op_b[W-1]) && (sum_w[W-1] != op_a[W-1]);
      end
      ALU_SUB: begin
        exec_res = diff_w[W-1:0];
        carry    = diff_w[W];
        ovf      = (op_a[W-1] != op_b[W-1]) && (diff_w[W-1] != op_a[W-1]);
      end
      ALU_AND:    exec_res = op_a & op_b;
      ALU_OR:     exec_res = op_a | op_b;
      ALU_XOR:    exec_res = op_a ^ op_b;
      ALU_SHL:    exec_res = op_a << op_b[SHW-1:0];
      ALU_SHR:    exec_res = $signed(op_a) >>> op_b[SHW-1:0];
      ALU_CMP_GT: exec_res[0] = $signed(op_a) > $signed(op_b);
      default:    reserved = 1'b1;
    endcase
    // On ADD/SUB overflow the true result always carries the sign of operand a.
    if (SATURATE && ovf) exec_res = op_a[W-1] ? SMIN : SMAX;
    exec_flags             = '0;
    exec_flags[FLAG_OVF]   = ovf;
    exec_flags[FLAG_CARRY] = carry;
    exec_flags[FLAG_NEG]   = exec_res[W-1];
    exec_flags[FLAG_ZERO]  = (exec_res == '0);
    if (reserved) exec_flags = FLAGS_RESERVED;
  end

  logic [STAGES-1:0] vld_q, vld_d;
  logic [W-1:0]      dat_q [STAGES];
  logic [W-1:0]      dat_d [STAGES];
  logic [3:0]        flg_q [STAGES];
  logic [3:0]        flg_d [STAGES];

  assign stall = vld_q[STAGES-1] && !result_ready;

  // Bubbles shift with the valids; payload only moves with a valid so the
  // last stage's data and flags hold across bubbles.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    flg_d = flg_q;
    if (!stall) begin
      vld_d[0] = join_fire;
      if (join_fire) begin
        dat_d[0] = exec_res;
        flg_d[0] = exec_flags;
      end
      for (int unsigned i = 1; i < STAGES; i++) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_d[i] = dat_q[i-1];
          flg_d[i] = flg_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        dat_q[i] <= '0;
        flg_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      flg_q <= flg_d;
    end
  end

  assign result_valid = vld_q[STAGES-1];
  assign result_data  = dat_q[STAGES-1];
  assign flags        = flg_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_alu.sv
// Directed bench for pipelined_alu across several parameterisations.
module tb_pipelined_alu;
  import fcore_alu_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  // Main instance: W=32, STAGES=1, wrap
  logic [31:0] a_ad, a_bd, a_rd;
  logic        a_av, a_bv, a_ar, a_br, a_rv, a_rr;
  logic [3:0]  a_op, a_fl;
  // Two W=8 instances sharing inputs: saturating and wrapping
  logic [7:0]  s_ad, s_bd, sat_rd, wrp_rd;
  logic        s_av, s_bv, sat_ar, sat_br, wrp_ar, wrp_br, sat_rv, wrp_rv, s_rr;
  logic [3:0]  s_op, sat_fl, wrp_fl;
  // Deep instance: W=32, STAGES=3
  logic [31:0] c_ad, c_bd, c_rd;
  logic        c_av, c_bv, c_ar, c_br, c_rv, c_rr;
  logic [3:0]  c_op, c_fl;

  pipelined_alu #(.DATA_WIDTH(32), .STAGES(1), .SATURATE(1'b0)) dut (
    .clock(clock), .reset(reset),
    .operand_a_data(a_ad), .operand_a_valid(a_av), .operand_a_ready(a_ar),
    .operand_b_data(a_bd), .operand_b_valid(a_bv), .operand_b_ready(a_br),
    .operation(a_op),
    .result_data(a_rd), .result_valid(a_rv), .result_ready(a_rr),
    .flags(a_fl));

  pipelined_alu #(.DATA_WIDTH(8), .STAGES(1), .SATURATE(1'b1)) dut_sat (
    .clock(clock), .reset(reset),
    .operand_a_data(s_ad), .operand_a_valid(s_av), .operand_a_ready(sat_ar),
    .operand_b_data(s_bd), .operand_b_valid(s_bv), .operand_b_ready(sat_br),
    .operation(s_op),
    .result_data(sat_rd), .result_valid(sat_rv), .result_ready(s_rr),
    .flags(sat_fl));

  pipelined_alu #(.DATA_WIDTH(8), .STAGES(1), .SATURATE(1'b0)) dut_wrap (
    .clock(clock), .reset(reset),
    .operand_a_data(s_ad), .operand_a_valid(s_av), .operand_a_ready(wrp_ar),
    .operand_b_data(s_bd), .operand_b_valid(s_bv), .operand_b_ready(wrp_br),
    .operation(s_op),
    .result_data(wrp_rd), .result_valid(wrp_rv), .result_ready(s_rr),
    .flags(wrp_fl));

  pipelined_alu #(.DATA_WIDTH(32), .STAGES(3), .SATURATE(1'b0)) dut_deep (
    .clock(clock), .reset(reset),
    .operand_a_data(c_ad), .operand_a_valid(c_av), .operand_a_ready(c_ar),
    .operand_b_data(c_bd), .operand_b_valid(c_bv), .operand_b_ready(c_br),
    .operation(c_op),
    .result_data(c_rd), .result_valid(c_rv), .result_ready(c_rr),
    .flags(c_fl));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sat_res;
    logic [3:0] sat_fl;
    logic [7:0] wrp_res;
    logic [3:0] wrp_fl;
  } vec8_t;

  vec_t  vecs  [15];
  vec8_t vecs8 [5];

  task automatic run_a(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic [3:0] fl, output int lat);
    a_op = op; a_ad = a; a_bd = b; a_av = 1'b1; a_bv = 1'b1;
    tick();
    a_av = 1'b0; a_bv = 1'b0;
    lat = 1;
    while (!a_rv && lat < 10) begin
      tick();
      lat++;
    end
    res = a_rd;
    fl  = a_fl;
  endtask

  task automatic run_8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] sr, output logic [3:0] sf,
                       output logic [7:0] wr, output logic [3:0] wf, output int lat);
    s_op = op; s_ad = a; s_bd = b; s_av = 1'b1; s_bv = 1'b1;
    tick();
    s_av = 1'b0; s_bv = 1'b0;
    lat = 1;
    while (!sat_rv && lat < 10) begin
      tick();
      lat++;
    end
    sr = sat_rd; sf = sat_fl; wr = wrp_rd; wf = wrp_fl;
  endtask

  logic [31:0] sa [10];
  logic [31:0] sb [10];
  int          got, stalls, unstable, bad_ar, bad_rv, spurious;
  logic        prev_stall;
  logic [31:0] prev_d;
  logic [3:0]  prev_f;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [3:0]  f;
    logic [7:0]  sr, wr;
    logic [3:0]  sf, wf;
    int          lat;

    vecs[0]  = '{"add_5_1",     ALU_ADD,    32'd5,          32'd1,          32'd6,          4'b0000};
    vecs[1]  = '{"sub_5_7",     ALU_SUB,    32'd5,          32'd7,          32'hFFFF_FFFE,  4'b0110};
    vecs[2]  = '{"and",         ALU_AND,    32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_00F0,  4'b0000};
    vecs[3]  = '{"or",          ALU_OR,     32'h0000_F000,  32'h0000_000F,  32'h0000_F00F,  4'b0000};
    vecs[4]  = '{"xor_self",    ALU_XOR,    32'h0000_AAAA,  32'h0000_AAAA,  32'h0,          4'b0001};
    vecs[5]  = '{"shl_1_4",     ALU_SHL,    32'd1,          32'd4,          32'd16,         4'b0000};
    vecs[6]  = '{"shr_m16_2",   ALU_SHR,    32'hFFFF_FFF0,  32'd2,          32'hFFFF_FFFC,  4'b0010};
    vecs[7]  = '{"cmp_3_m1",    ALU_CMP_GT, 32'd3,          32'hFFFF_FFFF,  32'd1,          4'b0000};
    vecs[8]  = '{"cmp_m1_3",    ALU_CMP_GT, 32'hFFFF_FFFF,  32'd3,          32'd0,          4'b0001};
    vecs[9]  = '{"rsvd_12",     4'd12,      32'd9,          32'd4,          32'd0,          4'b0001};
    vecs[10] = '{"add_ovf",     ALU_ADD,    32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  4'b1010};
    vecs[11] = '{"add_carry",   ALU_ADD,    32'hFFFF_FFFF,  32'd1,          32'h0,          4'b0101};
    vecs[12] = '{"sub_zero",    ALU_SUB,    32'd3,          32'd3,          32'h0,          4'b0001};
    vecs[13] = '{"shl_field",   ALU_SHL,    32'd1,          32'h0000_0024,  32'd16,         4'b0000};
    vecs[14] = '{"rsvd_15",     4'd15,      32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          4'b0001};

    vecs8[0] = '{"w8_add_100_100",  ALU_ADD, 8'h64, 8'h64, 8'h7F, 4'b1000, 8'hC8, 4'b1010};
    vecs8[1] = '{"w8_sub_m100_100", ALU_SUB, 8'h9C, 8'h64, 8'h80, 4'b1010, 8'h38, 4'b1000};
    vecs8[2] = '{"w8_add_m100_m100",ALU_ADD, 8'h9C, 8'h9C, 8'h80, 4'b1110, 8'h38, 4'b1100};
    vecs8[3] = '{"w8_add_50_27",    ALU_ADD, 8'd50, 8'd27, 8'h4D, 4'b0000, 8'h4D, 4'b0000};
    vecs8[4] = '{"w8_sub_min_1",    ALU_SUB, 8'h80, 8'h01, 8'h80, 4'b1010, 8'h7F, 4'b1000};

    for (int i = 0; i < 10; i++) begin
      sa[i] = 32'(i * 3 + 1);
      sb[i] = 32'(100 + i * 7);
    end

    reset = 1'b1;
    a_ad = '0; a_bd = '0; a_av = 1'b0; a_bv = 1'b0; a_op = '0; a_rr = 1'b1;
    s_ad = '0; s_bd = '0; s_av = 1'b0; s_bv = 1'b0; s_op = '0; s_rr = 1'b1;
    c_ad = '0; c_bd = '0; c_av = 1'b0; c_bv = 1'b0; c_op = ALU_ADD; c_rr = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    chk("rst_valid",  a_rv, 1'b0);
    chk("rst_data",   a_rd, 32'h0);
    chk("rst_flags",  a_fl, 4'h0);
    chk("rst_ready",  {a_ar, a_br, sat_ar, sat_br, wrp_ar, wrp_br, c_ar, c_br}, 8'hFF);
    chk("rst_valid_other", {sat_rv, wrp_rv, c_rv}, 3'b000);

    for (int i = 0; i < 15; i++) begin
      run_a(vecs[i].op, vecs[i].a, vecs[i].b, r, f, lat);
      chk({vecs[i].name, "_res"},   r,   vecs[i].res);
      chk({vecs[i].name, "_flags"}, f,   vecs[i].fl);
      chk({vecs[i].name, "_lat"},   lat, 2);
    end

    // Operand a arrives alone and must wait in its slot for b
    a_op = ALU_ADD; a_ad = 32'd2; a_av = 1'b1;
    tick();
    a_av = 1'b0;
    bad_ar = 0; bad_rv = 0;
    repeat (12) begin
      if (a_ar !== 1'b0 || a_br !== 1'b1) bad_ar++;
      if (a_rv !== 1'b0) bad_rv++;
      tick();
    end
    chk("held_a_ready_low", bad_ar, 0);
    chk("held_no_result", bad_rv, 0);
    a_bd = 32'd1; a_bv = 1'b1;
    tick();
    a_bv = 1'b0;
    chk("held_join_ready", a_ar, 1'b1);
    chk("held_join_novalid", a_rv, 1'b0);
    tick();
    chk("held_valid", a_rv, 1'b1);
    chk("held_res", a_rd, 32'd3);
    tick();

    for (int i = 0; i < 5; i++) begin
      run_8(vecs8[i].op, vecs8[i].a, vecs8[i].b, sr, sf, wr, wf, lat);
      chk({vecs8[i].name, "_sat_res"},   sr,  vecs8[i].sat_res);
      chk({vecs8[i].name, "_sat_flags"}, sf,  vecs8[i].sat_fl);
      chk({vecs8[i].name, "_wrp_res"},   wr,  vecs8[i].wrp_res);
      chk({vecs8[i].name, "_wrp_flags"}, wf,  vecs8[i].wrp_fl);
      chk({vecs8[i].name, "_lat"},       lat, 2);
    end

    // STAGES=3 stream of 10 pairs with result_ready low for cycles 4..7
    got = 0; stalls = 0; unstable = 0; prev_stall = 1'b0; prev_d = '0; prev_f = '0;
    fork
      begin : drv_a
        for (int i = 0; i < 10; i++) begin
          int  to;
          logic acc;
          c_ad = sa[i]; c_av = 1'b1; acc = 1'b0; to = 0;
          while (!acc && to < 50) begin
            @(negedge clock); #2;
            acc = c_ar;
            @(posedge clock); #1;
            to++;
          end
          if (!acc) begin
            chk("drv_a_accept", acc, 1'b1);
            break;
          end
        end
        c_av = 1'b0;
      end
      begin : drv_b
        for (int i = 0; i < 10; i++) begin
          int  to;
          logic acc;
          c_bd = sb[i]; c_bv = 1'b1; acc = 1'b0; to = 0;
          while (!acc && to < 50) begin
            @(negedge clock); #2;
            acc = c_br;
            @(posedge clock); #1;
            to++;
          end
          if (!acc) begin
            chk("drv_b_accept", acc, 1'b1);
            break;
          end
        end
        c_bv = 1'b0;
      end
      begin : mon
        for (int k = 0; k < 40; k++) begin
          @(negedge clock);
          c_rr = !(k >= 4 && k <= 7);
          #1;
          if (prev_stall && (c_rv !== 1'b1 || c_rd !== prev_d || c_fl !== prev_f)) unstable++;
          prev_stall = c_rv && !c_rr;
          prev_d = c_rd;
          prev_f = c_fl;
          if (prev_stall) stalls++;
          if (c_rv && c_rr) begin
            if (got < 10) chk($sformatf("stream_res%0d", got), c_rd, sa[got] + sb[got]);
            got++;
          end
        end
      end
    join
    chk("stream_count", got, 10);
    chk("stream_stable", unstable, 0);
    chk("stream_stalled", stalls > 0, 1'b1);

    // Reset with two results in flight and one operand held
    tick();
    c_rr = 1'b1;
    c_ad = 32'd1; c_bd = 32'd2; c_av = 1'b1; c_bv = 1'b1;
    tick();
    c_ad = 32'd3; c_bd = 32'd4;
    tick();
    c_ad = 32'd5; c_bv = 1'b0;
    tick();
    c_av = 1'b0;
    chk("pre_rst_a_held", c_ar, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", c_rv, 1'b0);
    chk("mid_rst_data", c_rd, 32'h0);
    chk("mid_rst_flags", c_fl, 4'h0);
    chk("mid_rst_ready", {c_ar, c_br}, 2'b11);
    spurious = 0;
    repeat (6) begin
      tick();
      if (c_rv !== 1'b0) spurious++;
    end
    chk("mid_rst_no_result", spurious, 0);
    c_ad = 32'd7; c_bd = 32'd8; c_av = 1'b1; c_bv = 1'b1;
    tick();
    c_av = 1'b0; c_bv = 1'b0;
    lat = 1;
    while (!c_rv && lat < 12) begin
      tick();
      lat++;
    end
    chk("post_rst_res", c_rd, 32'd15);
    chk("post_rst_lat", lat, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipelined_alu.md
# pipelined_alu

Parametrised, pipelined successor to the fcore ALU. It takes two AXI-stream operands that may arrive in different cycles and pairs them in per-operand holding slots. The pair then goes through a configurable-depth execution pipeline with full backpressure, optional saturating arithmetic and registered status flags. It sits between the fcore register-file read ports and the write-back stage, and replaces the fixed-width, single-stage ALU.

## Interface
- DATA_WIDTH, 32: operand and result width, ≥8, two's complement.
- STAGES, 1: execution register stages after the join, 1..4.
- SATURATE, 0: 1 = ADD/SUB clamp on signed overflow; 0 = wrap.
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- operand_a  axi_stream slave  DATA_WIDTH  first operand (data, valid, ready).
- operand_b  axi_stream slave  DATA_WIDTH  second operand.
- operation  in  4  opcode, sampled in the join cycle.
- result  axi_stream master  DATA_WIDTH  result (data, valid, ready).
- flags  out  4  {overflow, carry, negative, zero}, registered with result.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB (a−b), 2 AND, 3 OR, 4 XOR.
  - 5 SHL by b[$clog2(DATA_WIDTH)-1:0].
  - 6 arithmetic SHR by the same field.
  - 7 CMP_GT (signed a>b → 1, else 0).
  - 8..15 reserved: result 0, flags 4'b0001.
- Holding slots:
  - Each operand has one slot: hold_x_data, hold_x_valid.
  - A handshake (valid && ready) loads the slot and sets hold_x_valid.
- operand_x.ready = !hold_x_valid || join.
- join = hold_a_valid && hold_b_valid && !stall. When join fires:
  - both slots clear, unless refilled in the same cycle;
  - the operation is sampled;
  - the result and flags enter stage 1.
- Operands arriving any number of cycles apart are paired in arrival order. There is no reordering and no timeout.
- Pipeline:
  - STAGES registers, each with a valid bit.
  - stall = last_valid && !result.ready.
  - When stalled, every stage and both slots hold.
  - Otherwise all stages shift by one; bubbles propagate and are not compressed.
- Arithmetic: computed at DATA_WIDTH+1 bits.
  - carry = bit DATA_WIDTH; for SUB, carry = borrow.
  - overflow = signed overflow, ADD/SUB only; 0 for every other opcode.
  - SATURATE=1 with overflow: result = 2^(W−1)−1 if the true result is positive, else −2^(W−1). overflow still reports 1.
- zero and negative are taken from the final result, after saturation.
- flags change only when a new result is loaded into the last stage. They hold otherwise.

## Timing
- Reset values:
  - result.valid=0, result.data=0, flags=0.
  - operand_a.ready = operand_b.ready = 1.
  - Both slots empty, all stage valids 0.
- Reset mid-operation discards held operands and in-flight results. No result is emitted for them.
- Latency:
  - Second operand handshake at cycle t: join at t+1, result.valid at t+1+STAGES when unstalled.
  - STAGES=1 gives 2 cycles.
- Throughput: one result per cycle when both operands stream and result.ready=1.
- result.data and flags are stable while result.valid && !result.ready.
- A slot that is full and not joining holds ready low. The master must keep data and valid until accepted.
- Simultaneous join and new handshake on the same operand: the slot reloads with the new data and hold_x_valid stays 1.

## Structure
- Package fcore_alu_pkg:
  - alu_op_t enum (4 bits, codes above);
  - flag bit index constants: FLAG_ZERO=0, FLAG_NEG=1, FLAG_CARRY=2, FLAG_OVF=3.
- Sub-module alu_operand_join: the two holding slots, the ready logic and the join/stall qualification.
- The execution datapath and stage registers live in pipelined_alu.

## Test plan
- a=5, b=1 in the same cycle, ADD, STAGES=1 → result 6 two cycles after the handshake; flags 0.
- a=2, then b=1 12 cycles later, ADD → a held and operand_a.ready=0 in between; result 3 at b+2 cycles.
- W=8, SATURATE=1: ADD 100+100 → 127 with overflow=1. SUB −100−100 → −128. With SATURATE=0, ADD 100+100 → −56 with overflow=1 and negative=1.
- STAGES=3, 10 back-to-back pairs with result.ready low for cycles 4–7 → all 10 results in order, no loss or duplication, data stable while stalled.
- Opcodes 5/6/7 and reserved 12: SHL 1 by 4 → 16; SHR −16 by 2 → −4; CMP_GT 3>−1 → 1; opcode 12 → 0 with flags 4'b0001.
- Reset asserted with one operand held and two results in flight → no result.valid after reset; next pair 7+8 → 15.
